// File: rtl/sub_fifo.sv
// sub_fifo: synchronous valid/ready FIFO with occupancy count.
// Buffers the register-stage stream ahead of the consuming logic.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready push handshake (push = in_valid & in_ready)
//   in_data           write data, WIDTH bits
//   out_valid/out_ready pop handshake (pop = out_valid & out_ready)
//   out_data          head entry, zero while empty
//   count             occupancy 0..DEPTH
//   almost_full       present only when SUB_FIFO_ALMOST_FULL_EN is defined
//
// Configuration macro: SUB_FIFO_ALMOST_FULL_EN adds the almost_full output.
module sub_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
`ifdef SUB_FIFO_ALMOST_FULL_EN
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full
`else
  output logic [$clog2(DEPTH):0]     count
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW-1:0]    wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0]    count_nxt;
  logic [WIDTH-1:0] head_nxt;
  logic             push, pop;

  // Next-state: pointers, occupancy and the word that will sit at the head.
  always_comb begin
    push       = in_valid & in_ready;
    pop        = out_valid & out_ready;
    count_nxt  = count;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    head_nxt   = '0;

    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase

    if (push) wr_ptr_nxt = wr_ptr + PW'(1);
    if (pop)  rd_ptr_nxt = rd_ptr + PW'(1);

    // The head is the word written this cycle only when it lands at the new
    // read pointer (empty push, or single-entry push&pop).
    if (count_nxt != '0) begin
      if (push && (rd_ptr_nxt == wr_ptr)) head_nxt = in_data;
      else                                 head_nxt = mem[rd_ptr_nxt];
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= '0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_nxt;
      out_valid <= (count_nxt != '0);
      in_ready  <= (count_nxt != CW'(DEPTH));
      out_data  <= head_nxt;
    end
  end

`ifdef SUB_FIFO_ALMOST_FULL_EN
  // Flags within one entry of full, tracking the updated occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) almost_full <= 1'b0;
    else        almost_full <= (count_nxt >= CW'(DEPTH - 1));
  end
`endif

endmodule
